// File: rtl/unidade_controle.sv
// Multicycle control unit for the RV64 subset datapath (ld, sd, add, sub, addi, ebreak).
// Fetches from MemoriaInstrucao and sequences the register-file, ULA and data-memory controls.
module unidade_controle #(
  parameter int PC_W     = 5,
  parameter int XLEN     = 64,
  parameter int START_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [31:0]     instr,
  output logic [PC_W-1:0] endr,
  output logic [4:0]      Ra,
  output logic [4:0]      Rb,
  output logic [4:0]      Rw,
  output logic            WeR,
  output logic            WeM,
  output logic            sel_dinR,
  output logic            soma_ou_subtrai,
  output logic            subtraindo,
  output logic [1:0]      escolhe_entrada1,
  output logic [1:0]      escolhe_entrada2,
  output logic [XLEN-1:0] constante,
  output logic            busy,
  output logic            halted,
  output logic            erro,
  output logic [2:0]      state_dbg
);

  // start is a level request sampled on posedge; it is accepted only in IDLE or HALT
  // and ignored while busy. instr is the synchronous memory output for the previous endr.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_ADDI    = 3'd2,
    OP_LD      = 3'd3,
    OP_SD      = 3'd4,
    OP_EBREAK  = 3'd5,
    OP_ILLEGAL = 3'd6
  } op_t;

  localparam logic [6:0]  OPC_R      = 7'b0110011;
  localparam logic [6:0]  OPC_I      = 7'b0010011;
  localparam logic [6:0]  OPC_LD     = 7'b0000011;
  localparam logic [6:0]  OPC_SD     = 7'b0100011;
  localparam logic [31:0] EBREAK_W   = 32'h0010_0073;
  localparam logic [1:0]  SEL_A      = 2'd1;
  localparam logic [1:0]  SEL_B      = 2'd0;
  localparam logic [1:0]  SEL_C      = 2'd2;
  localparam logic [PC_W-1:0] PC0    = PC_W'(START_PC);

  state_t          state, state_nxt;
  op_t             op_q, dec_op;
  logic [PC_W-1:0] pc;
  logic [31:15]    ir_hi;
  logic [11:7]     ir_lo;
  logic            erro_q;
  logic            launch, retire, in_op;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_s;

  function automatic op_t decode(input logic [31:0] w);
    op_t op;
    op = OP_ILLEGAL;
    if (w == EBREAK_W) begin
      op = OP_EBREAK;
    end else begin
      case (w[6:0])
        OPC_R: begin
          if (w[14:12] == 3'b000) begin
            if (w[31:25] == 7'b0000000)      op = OP_ADD;
            else if (w[31:25] == 7'b0100000) op = OP_SUB;
          end
        end
        OPC_I:   if (w[14:12] == 3'b000) op = OP_ADDI;
        OPC_LD:  if (w[14:12] == 3'b011) op = OP_LD;
        OPC_SD:  if (w[14:12] == 3'b011) op = OP_SD;
        default: op = OP_ILLEGAL;
      endcase
    end
    return op;
  endfunction

  assign dec_op = decode(instr);
  assign launch = start && ((state == S_IDLE) || (state == S_HALT));
  // pc advances when the instruction leaves its last cycle: WB, or MEM for a store
  assign retire = (state == S_WB) || ((state == S_MEM) && (op_q == OP_SD));
  assign in_op  = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

  assign rd    = ir_lo[11:7];
  assign rs1   = ir_hi[19:15];
  assign rs2   = ir_hi[24:20];
  assign imm_i = {{(XLEN-12){ir_hi[31]}}, ir_hi[31:20]};
  assign imm_s = {{(XLEN-12){ir_hi[31]}}, ir_hi[31:25], ir_lo[11:7]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      pc     <= PC0;
      ir_hi  <= '0;
      ir_lo  <= '0;
      op_q   <= OP_ILLEGAL;
      erro_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        pc     <= PC0;
        erro_q <= 1'b0;
      end else if (retire) begin
        pc <= pc + 1'b1;
      end
      if (state == S_DECODE) begin
        ir_hi <= instr[31:15];
        ir_lo <= instr[11:7];
        op_q  <= dec_op;
        if (dec_op == OP_ILLEGAL) erro_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    Ra               = 5'd0;
    Rb               = 5'd0;
    Rw               = 5'd0;
    WeR              = 1'b0;
    WeM              = 1'b0;
    sel_dinR         = 1'b0;
    subtraindo       = 1'b0;
    escolhe_entrada1 = SEL_B;
    escolhe_entrada2 = SEL_B;
    constante        = '0;

    case (state)
      S_IDLE, S_HALT: if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = ((dec_op == OP_EBREAK) || (dec_op == OP_ILLEGAL)) ? S_HALT : S_EXEC;
      S_EXEC:   state_nxt = ((op_q == OP_LD) || (op_q == OP_SD)) ? S_MEM : S_WB;
      S_MEM:    state_nxt = (op_q == OP_LD) ? S_WB : S_FETCH;
      S_WB:     state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase

    // Controls are a pure function of the latched instruction, so they stay constant EXEC..WB
    if (in_op) begin
      case (op_q)
        OP_ADD, OP_SUB: begin
          Ra               = rs1;
          Rb               = rs2;
          escolhe_entrada1 = SEL_A;
          escolhe_entrada2 = SEL_B;
          subtraindo       = (op_q == OP_SUB);
        end
        OP_ADDI: begin
          Rb               = rs1;
          escolhe_entrada1 = SEL_B;
          escolhe_entrada2 = SEL_C;
          constante        = imm_i;
        end
        OP_LD: begin
          Rb               = rs1;
          escolhe_entrada1 = SEL_C;
          escolhe_entrada2 = SEL_B;
          constante        = imm_i;
          sel_dinR         = 1'b1;
        end
        OP_SD: begin
          Rb               = rs1;
          Ra               = rs2;
          escolhe_entrada1 = SEL_B;
          escolhe_entrada2 = SEL_C;
          constante        = imm_s;
        end
        default: ;
      endcase
      if (op_q != OP_SD) Rw = rd;
    end

    if ((state == S_WB) && (rd != 5'd0))   WeR = 1'b1;
    if ((state == S_MEM) && (op_q == OP_SD)) WeM = 1'b1;
  end

  assign endr            = pc;
  assign busy            = in_op || (state == S_FETCH) || (state == S_DECODE);
  assign soma_ou_subtrai = busy;
  assign halted          = (state == S_HALT);
  assign erro            = erro_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: synchronous instruction memory model, per-instruction
// expectations from an ISA-level reference model, and a register-write scoreboard.
module tb_unidade_controle;

  localparam int PC_W = 5;
  localparam int XLEN = 64;

  logic            clk;
  logic            reset;
  logic            start;
  logic [31:0]     instr;
  logic [PC_W-1:0] endr;
  logic [4:0]      Ra, Rb, Rw;
  logic            WeR, WeM, sel_dinR, soma_ou_subtrai, subtraindo;
  logic [1:0]      escolhe_entrada1, escolhe_entrada2;
  logic [XLEN-1:0] constante;
  logic            busy, halted, erro;
  logic [2:0]      state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  bit noisy_start = 0;

  logic [31:0] imem [32];
  logic [4:0]  exp_q[$];

  typedef struct {
    int          cpi;
    bit          halt;
    bit          err;
    bit          wer;
    bit          wem;
    bit          chk_ra;
    bit          chk_k;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rw;
    logic [1:0]  e1;
    logic [1:0]  e2;
    logic [63:0] k;
    bit          sub;
    bit          seld;
  } exp_t;

  unidade_controle #(.PC_W(PC_W), .XLEN(XLEN), .START_PC(0)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .endr(endr),
    .Ra(Ra), .Rb(Rb), .Rw(Rw), .WeR(WeR), .WeM(WeM), .sel_dinR(sel_dinR),
    .soma_ou_subtrai(soma_ou_subtrai), .subtraindo(subtraindo),
    .escolhe_entrada1(escolhe_entrada1), .escolhe_entrada2(escolhe_entrada2),
    .constante(constante), .busy(busy), .halted(halted), .erro(erro),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MemoriaInstrucao: dout valid one cycle after the address
  always @(posedge clk) instr <= imem[endr];

  // scoreboard: every register write must match the next expected destination
  always @(negedge clk) begin
    if (WeR === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wer_unexpected: Rw=%0d, expected no register write", Rw);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if (Rw !== e) begin
          n_fail++;
          $display("FAIL wer_dest: Rw=%0d expected %0d", Rw, e);
        end
      end
    end
  end

  // ISA-level reference: what one instruction word must do to the controls
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic [6:0] opc; logic [2:0] f3; logic [6:0] f7;
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    e.cpi = 2; e.halt = 1; e.err = 1; e.wer = 0; e.wem = 0; e.chk_ra = 0; e.chk_k = 0;
    e.ra = 0; e.rb = 0; e.rw = w[11:7]; e.e1 = 0; e.e2 = 0; e.k = 0; e.sub = 0; e.seld = 0;
    if (w == 32'h0010_0073) begin
      e.err = 0;
    end else if (opc == 7'b0110011 && f3 == 3'b000 && (f7 == 7'h00 || f7 == 7'h20)) begin
      e.halt = 0; e.err = 0; e.cpi = 4; e.ra = w[19:15]; e.rb = w[24:20]; e.chk_ra = 1;
      e.e1 = 2'd1; e.e2 = 2'd0; e.sub = (f7 == 7'h20); e.wer = (w[11:7] != 0);
    end else if (opc == 7'b0010011 && f3 == 3'b000) begin
      e.halt = 0; e.err = 0; e.cpi = 4; e.rb = w[19:15]; e.e1 = 2'd0; e.e2 = 2'd2;
      e.k = {{52{w[31]}}, w[31:20]}; e.chk_k = 1; e.wer = (w[11:7] != 0);
    end else if (opc == 7'b0000011 && f3 == 3'b011) begin
      e.halt = 0; e.err = 0; e.cpi = 5; e.rb = w[19:15]; e.e1 = 2'd2; e.e2 = 2'd0;
      e.k = {{52{w[31]}}, w[31:20]}; e.chk_k = 1; e.seld = 1; e.wer = (w[11:7] != 0);
    end else if (opc == 7'b0100011 && f3 == 3'b011) begin
      e.halt = 0; e.err = 0; e.cpi = 4; e.rb = w[19:15]; e.ra = w[24:20]; e.chk_ra = 1;
      e.e1 = 2'd0; e.e2 = 2'd2; e.k = {{52{w[31]}}, w[31:25], w[11:7]}; e.chk_k = 1; e.wem = 1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [4:0] rd, rs1, rs2; logic [11:0] imm; int k;
    rd  = 5'($urandom_range(0, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    imm = 12'($urandom_range(0, 4095));
    k   = $urandom_range(0, 4);
    case (k)
      0:       return {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
      1:       return {7'h20, rs2, rs1, 3'b000, rd, 7'b0110011};
      2:       return {imm, rs1, 3'b000, rd, 7'b0010011};
      3:       return {imm, rs1, 3'b011, rd, 7'b0000011};
      default: return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
    endcase
  endfunction

  // driver: one-cycle start pulse, returns at the negedge showing FETCH
  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // follows one instruction from its FETCH sample until pc moves or the unit halts
  task automatic check_instr(input logic [31:0] w, input string tag);
    exp_t e;
    logic [PC_W-1:0] p, p_nxt;
    int cyc, nwer, nwem, wer_at, wem_at;
    bit sos_bad;
    logic [4:0] c_ra, c_rb; logic [1:0] c_e1, c_e2; logic [63:0] c_k; logic c_sub, c_seld;
    e = model(w);
    p = endr; p_nxt = p + 1'b1;
    if (e.wer) exp_q.push_back(e.rw);
    cyc = 0; nwer = 0; nwem = 0; wer_at = 0; wem_at = 0; sos_bad = 0;
    c_ra = 0; c_rb = 0; c_e1 = 0; c_e2 = 0; c_k = 0; c_sub = 0; c_seld = 0;
    while (busy === 1'b1 && endr === p && cyc < 12) begin
      cyc++;
      if (soma_ou_subtrai !== 1'b1) sos_bad = 1;
      if (WeR === 1'b1) begin nwer++; wer_at = cyc; end
      if (WeM === 1'b1) begin nwem++; wem_at = cyc; end
      c_ra = Ra; c_rb = Rb; c_e1 = escolhe_entrada1; c_e2 = escolhe_entrada2;
      c_k = constante; c_sub = subtraindo; c_seld = sel_dinR;
      if (noisy_start) start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    n_tests++; if (cyc != e.cpi) begin n_fail++; $display("FAIL %s cycles: got %0d expected %0d", tag, cyc, e.cpi); end
    n_tests++; if (nwer != int'(e.wer)) begin n_fail++; $display("FAIL %s wer_count: got %0d expected %0d", tag, nwer, e.wer); end
    n_tests++; if (nwem != int'(e.wem)) begin n_fail++; $display("FAIL %s wem_count: got %0d expected %0d", tag, nwem, e.wem); end
    n_tests++; if (sos_bad) begin n_fail++; $display("FAIL %s soma_ou_subtrai: got 0 while busy expected 1", tag); end
    if (e.wer) begin
      n_tests++; if (wer_at != e.cpi) begin n_fail++; $display("FAIL %s wer_cycle: got %0d expected %0d", tag, wer_at, e.cpi); end
    end
    if (e.wem) begin
      n_tests++; if (wem_at != e.cpi) begin n_fail++; $display("FAIL %s wem_cycle: got %0d expected %0d", tag, wem_at, e.cpi); end
    end
    if (e.halt) begin
      n_tests++;
      if (halted !== 1'b1 || busy !== 1'b0 || erro !== e.err || WeR !== 1'b0 || WeM !== 1'b0) begin
        n_fail++;
        $display("FAIL %s halt: halted=%b busy=%b erro=%b WeR=%b WeM=%b expected 1 0 %b 0 0",
                 tag, halted, busy, erro, WeR, WeM, e.err);
      end
    end else begin
      n_tests++; if (endr !== p_nxt) begin n_fail++; $display("FAIL %s next_pc: got %0d expected %0d", tag, endr, p_nxt); end
      n_tests++; if (c_rb !== e.rb) begin n_fail++; $display("FAIL %s Rb: got %0d expected %0d", tag, c_rb, e.rb); end
      n_tests++;
      if (c_e1 !== e.e1 || c_e2 !== e.e2) begin
        n_fail++; $display("FAIL %s escolhe: got %0d/%0d expected %0d/%0d", tag, c_e1, c_e2, e.e1, e.e2);
      end
      n_tests++;
      if (c_sub !== e.sub || c_seld !== e.seld) begin
        n_fail++; $display("FAIL %s sub/sel_dinR: got %b/%b expected %b/%b", tag, c_sub, c_seld, e.sub, e.seld);
      end
      if (e.chk_ra) begin
        n_tests++; if (c_ra !== e.ra) begin n_fail++; $display("FAIL %s Ra: got %0d expected %0d", tag, c_ra, e.ra); end
      end
      if (e.chk_k) begin
        n_tests++; if (c_k !== e.k) begin n_fail++; $display("FAIL %s constante: got %h expected %h", tag, c_k, e.k); end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (endr !== 5'd0 || Ra !== 5'd0 || Rb !== 5'd0 || Rw !== 5'd0) begin
      n_fail++; $display("FAIL reset_addr: endr=%0d Ra=%0d Rb=%0d Rw=%0d expected all 0", endr, Ra, Rb, Rw);
    end
    n_tests++;
    if ({WeR, WeM, sel_dinR, soma_ou_subtrai, subtraindo} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: WeR WeM sel sos sub=%b expected 00000",
                         {WeR, WeM, sel_dinR, soma_ou_subtrai, subtraindo});
    end
    n_tests++;
    if (escolhe_entrada1 !== 2'd0 || escolhe_entrada2 !== 2'd0 || constante !== 64'd0) begin
      n_fail++; $display("FAIL reset_ula: esc=%0d/%0d constante=%h expected 0/0/0",
                         escolhe_entrada1, escolhe_entrada2, constante);
    end
    n_tests++;
    if (busy !== 1'b0 || halted !== 1'b0 || erro !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: busy=%b halted=%b erro=%b expected 000", busy, halted, erro);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle_hold();
    bit moved;
    moved = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || endr !== 5'd0) moved = 1;
    end
    n_tests++; if (moved) begin n_fail++; $display("FAIL idle_hold: busy=%b endr=%0d expected 0/0", busy, endr); end
  endtask

  task automatic test_directed();
    logic [31:0] prog [7];
    prog = '{32'h0010_3083, 32'h0020_81B3, 32'h4020_8233, 32'hFFD2_0293,
             32'h0010_32A3, 32'h0070_0013, 32'h0010_0073};
    for (int i = 0; i < 7; i++) imem[i] = prog[i];
    start_run();
    n_tests++; if (busy !== 1'b1 || endr !== 5'd0) begin n_fail++; $display("FAIL start: busy=%b endr=%0d expected 1/0", busy, endr); end
    for (int i = 0; i < 7; i++) check_instr(prog[i], $sformatf("dir%0d", i));
  endtask

  task automatic test_illegal();
    imem[0] = 32'hFFFF_FFFF;
    start_run();
    n_tests++;
    if (halted !== 1'b0 || busy !== 1'b1 || endr !== 5'd0) begin
      n_fail++; $display("FAIL restart: halted=%b busy=%b endr=%0d expected 0/1/0", halted, busy, endr);
    end
    check_instr(32'hFFFF_FFFF, "illegal_ffff");
  endtask

  task automatic test_random();
    logic [31:0] w;
    exp_t e;
    for (int i = 0; i < 32; i++) imem[i] = rand_legal();
    imem[31] = 32'h0070_0013;
    start_run();
    n_tests++; if (erro !== 1'b0) begin n_fail++; $display("FAIL erro_clear: got %b expected 0", erro); end
    noisy_start = 1;
    for (int i = 0; i < 40; i++) check_instr(imem[endr], $sformatf("rnd%0d", i));
    noisy_start = 0;
    do begin
      w = $urandom;
      e = model(w);
    end while (!e.err);
    imem[endr] = w;
    check_instr(w, "rnd_illegal");
  endtask

  // reset while an instruction sits in MEM: strobes drop at once and no write follows
  task automatic test_reset_mid(input logic [31:0] w, input string tag);
    imem[0] = 32'h0070_0013;
    imem[1] = w;
    start_run();
    check_instr(32'h0070_0013, {tag, "_pre"});
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if (WeR !== 1'b0 || WeM !== 1'b0 || endr !== 5'd0 || busy !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL %s: WeR=%b WeM=%b endr=%0d busy=%b halted=%b expected 0 0 0 0 0",
                         tag, WeR, WeM, endr, busy, halted);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0 || WeM !== 1'b0) begin n_fail++; $display("FAIL %s_idle: busy=%b WeM=%b expected 0/0", tag, busy, WeM); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instr = 32'd0;
    for (int i = 0; i < 32; i++) imem[i] = 32'd0;
    test_reset();
    test_idle_hold();
    test_directed();
    test_illegal();
    test_random();
    test_reset_mid(32'h0010_3083, "reset_ld_mem");
    test_reset_mid(32'h0010_32A3, "reset_sd_mem");
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL wer_missing: %0d writes outstanding expected 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
